// File: rtl/cru_int_ctrl.sv
// CRU-mapped interrupt controller: 16 flag bits, NCH masked interrupt channels, fixed priority.
// Optional build macro INTCTL_EDGE_EN enables per-channel rising-edge capture selected by EDGE_MASK.
module cru_int_ctrl #(
  parameter int unsigned    NCH       = 4,
  parameter logic [9:0]     BASE      = 10'h07B,
  parameter logic [NCH-1:0] EDGE_MASK = '0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [15:0]    cab,
  input  logic           cruout,
  input  logic           cruclk,
  input  logic [3:0]     bst,
  input  logic [NCH-1:0] irq,
  output logic           cruin,
  output logic           sel,
  output logic           int_o,
  output logic [3:0]     ic
);

  logic [15:0]    flag_q, flag_d;
  logic [NCH-1:0] mask_q, mask_d;
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] chan_hit, inta_clr, live, set_ev, act;
  logic [4:0]     idx;
  logic           flag_hit;
  logic           wr;
  logic           unused_cab0;

  assign sel         = (cab[15:6] == BASE);
  assign idx         = cab[5:1];
  assign flag_hit    = sel & ~idx[4];
  assign wr          = cruclk & sel;
  assign unused_cab0 = cab[0];

  always_comb begin
    chan_hit = '0;
    inta_clr = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      chan_hit[k] = sel && (idx == 5'(16 + k));
      inta_clr[k] = (bst == 4'b0101) && (cab[5:2] == 4'(k + 1));
    end
  end

`ifdef INTCTL_EDGE_EN
  logic [NCH-1:0] irq_dly_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_dly_q <= '0;
    else       irq_dly_q <= irq;
  end

  // Edge channels never show the raw line; they only report the captured event.
  assign live   = irq & ~EDGE_MASK;
  assign set_ev = live | (irq & ~irq_dly_q & EDGE_MASK);
`else
  assign live   = irq;
  assign set_ev = irq;
`endif

  always_comb begin
    flag_d = flag_q;
    mask_d = mask_q;
    pend_d = pend_q;
    if (wr && flag_hit) flag_d[idx[3:0]] = cruout;
    for (int k = 0; k < int'(NCH); k++) begin
      if (wr && chan_hit[k]) mask_d[k] = cruout;
      // A new request always wins over a same-cycle acknowledge or mask clear.
      if (set_ev[k])
        pend_d[k] = 1'b1;
      else if (inta_clr[k] || (wr && chan_hit[k] && !cruout))
        pend_d[k] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_q <= '0;
      mask_q <= '0;
      pend_q <= '0;
    end else begin
      flag_q <= flag_d;
      mask_q <= mask_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    cruin = 1'b1;
    if (flag_hit)
      cruin = flag_q[idx[3:0]];
    else if (|chan_hit)
      cruin = |(chan_hit & (pend_q | live));
  end

  assign act   = (pend_q | live) & mask_q;
  assign int_o = |act;

  always_comb begin
    ic = 4'h0;
    for (int k = int'(NCH) - 1; k >= 0; k--) begin
      if (act[k]) ic = 4'(k + 1);
    end
  end

endmodule

// File: tb/tb_cru_int_ctrl.sv
// Directed vector bench for cru_int_ctrl: table of CRU accesses and IRQ patterns plus reset/edge sequences.
module tb_cru_int_ctrl;

  typedef struct {
    logic [15:0] cab;
    logic        cruout;
    logic        cruclk;
    logic [3:0]  bst;
    logic [3:0]  irq;
    logic        e_sel;
    logic        e_cruin;
    logic        e_int;
    logic [3:0]  e_ic;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cab = '0;
  logic        cruout = 1'b0;
  logic        cruclk = 1'b0;
  logic [3:0]  bst = '0;
  logic [3:0]  irq = '0;
  logic        cruin, sel, int_o;
  logic [3:0]  ic;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[$];

  cru_int_ctrl #(.NCH(4), .BASE(10'h07B), .EDGE_MASK(4'b0001)) dut (
    .clk(clk), .reset(reset), .cab(cab), .cruout(cruout), .cruclk(cruclk),
    .bst(bst), .irq(irq), .cruin(cruin), .sel(sel), .int_o(int_o), .ic(ic)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] c, input logic d, input logic s, input logic [3:0] b,
                     input logic [3:0] q, input logic es, input logic ec, input logic ei,
                     input logic [3:0] eic);
    vec_t v;
    v.cab = c; v.cruout = d; v.cruclk = s; v.bst = b; v.irq = q;
    v.e_sel = es; v.e_cruin = ec; v.e_int = ei; v.e_ic = eic;
    tbl.push_back(v);
  endtask

  // Drive on the falling edge, check the settled outputs before the next rising edge commits.
  task automatic apply(input string name, input logic [15:0] c, input logic d, input logic s,
                       input logic [3:0] b, input logic [3:0] q, input logic es, input logic ec,
                       input logic ei, input logic [3:0] eic);
    @(negedge clk);
    cab = c; cruout = d; cruclk = s; bst = b; irq = q;
    #1;
    chk({name, ".sel"},   16'(sel),   16'(es));
    chk({name, ".cruin"}, 16'(cruin), 16'(ec));
    chk({name, ".int"},   16'(int_o), 16'(ei));
    chk({name, ".ic"},    16'(ic),    16'(eic));
  endtask

  initial begin
    //   cab       d  s  bst  irq      sel cruin int ic
    add(16'h0000, 0, 0, 4'd0, 4'b0000, 0, 1, 0, 4'd0);
    add(16'h1EC6, 1, 1, 4'd0, 4'b0000, 1, 0, 0, 4'd0);
    add(16'h1EC6, 0, 0, 4'd0, 4'b0000, 1, 1, 0, 4'd0);
    add(16'h1EC8, 0, 0, 4'd0, 4'b0000, 1, 0, 0, 4'd0);
    add(16'h1EC4, 0, 0, 4'd0, 4'b0000, 1, 0, 0, 4'd0);
    add(16'h1EFE, 1, 1, 4'd0, 4'b0000, 1, 1, 0, 4'd0);
    add(16'h0EC8, 1, 1, 4'd0, 4'b0000, 0, 1, 0, 4'd0);
    add(16'h1EC8, 0, 0, 4'd0, 4'b0000, 1, 0, 0, 4'd0);
    add(16'h1EE2, 1, 1, 4'd0, 4'b0000, 1, 0, 0, 4'd0);
    add(16'h0000, 0, 0, 4'd0, 4'b0010, 0, 1, 1, 4'd2);
    add(16'h0000, 0, 0, 4'd0, 4'b0010, 0, 1, 1, 4'd2);
    add(16'h0000, 0, 0, 4'd0, 4'b0010, 0, 1, 1, 4'd2);
    add(16'h0000, 0, 0, 4'd0, 4'b0000, 0, 1, 1, 4'd2);
    add(16'h1EE2, 0, 0, 4'd0, 4'b0000, 1, 1, 1, 4'd2);
    add(16'h1EC8, 0, 0, 4'd5, 4'b0000, 1, 0, 1, 4'd2);
    add(16'h0000, 0, 0, 4'd0, 4'b0000, 0, 1, 0, 4'd0);
    add(16'h1EE2, 0, 0, 4'd0, 4'b0000, 1, 0, 0, 4'd0);
    add(16'h1EE6, 0, 0, 4'd0, 4'b1000, 1, 1, 0, 4'd0);
    add(16'h1EE6, 0, 0, 4'd0, 4'b0000, 1, 1, 0, 4'd0);
    add(16'h1EE6, 0, 1, 4'd0, 4'b0000, 1, 1, 0, 4'd0);
    add(16'h1EE6, 0, 0, 4'd0, 4'b0000, 1, 0, 0, 4'd0);
    add(16'h1EE4, 1, 1, 4'd0, 4'b0000, 1, 0, 0, 4'd0);
    add(16'h1EE6, 1, 1, 4'd0, 4'b0000, 1, 0, 0, 4'd0);
    add(16'h0000, 0, 0, 4'd0, 4'b0100, 0, 1, 1, 4'd3);
    add(16'h0000, 0, 0, 4'd0, 4'b0001, 0, 1, 1, 4'd3);
    add(16'h1EE0, 1, 1, 4'd0, 4'b0000, 1, 1, 1, 4'd3);
    add(16'h0000, 0, 0, 4'd0, 4'b0000, 0, 1, 1, 4'd1);
    add(16'h1EC4, 0, 0, 4'd5, 4'b0000, 1, 0, 1, 4'd1);
    add(16'h0000, 0, 0, 4'd0, 4'b0000, 0, 1, 1, 4'd3);
    add(16'h1ECC, 0, 0, 4'd5, 4'b0000, 1, 0, 1, 4'd3);
    add(16'h0000, 0, 0, 4'd0, 4'b0000, 0, 1, 0, 4'd0);
    add(16'h1EC8, 0, 0, 4'd5, 4'b0010, 1, 0, 1, 4'd2);
    add(16'h0000, 0, 0, 4'd0, 4'b0000, 0, 1, 1, 4'd2);
    add(16'h1EC8, 0, 0, 4'd5, 4'b0000, 1, 0, 1, 4'd2);
    add(16'h0000, 0, 0, 4'd0, 4'b0000, 0, 1, 0, 4'd0);

    #12;
    chk("rst.int",   16'(int_o), 16'd0);
    chk("rst.ic",    16'(ic),    16'd0);
    chk("rst.cruin", 16'(cruin), 16'd1);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i])
      apply($sformatf("v%0d", i), tbl[i].cab, tbl[i].cruout, tbl[i].cruclk, tbl[i].bst,
            tbl[i].irq, tbl[i].e_sel, tbl[i].e_cruin, tbl[i].e_int, tbl[i].e_ic);

    // Reset in the middle of a flag write with pend=4'hA, mask=4'hF.
    apply("pa0", 16'h0000, 0, 0, 4'd0, 4'b1010, 0, 1, 1, 4'd2);
    apply("pa1", 16'h0000, 0, 0, 4'd0, 4'b0000, 0, 1, 1, 4'd2);
    @(negedge clk);
    cab = 16'h1EC8; cruout = 1'b1; cruclk = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("mid.int", 16'(int_o), 16'd0);
    chk("mid.ic",  16'(ic),    16'd0);
    cab = 16'h0000;
    #1;
    chk("mid.cruin", 16'(cruin), 16'd1);
    chk("mid.sel",   16'(sel),   16'd0);
    cab = 16'h1EC6;
    #1;
    chk("mid.flag3", 16'(cruin), 16'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; cruclk = 1'b0; cruout = 1'b0;
    apply("post.pend1", 16'h1EE2, 0, 0, 4'd0, 4'b0000, 1, 0, 0, 4'd0);
    apply("post.mask",  16'h0000, 0, 0, 4'd0, 4'b0010, 0, 1, 0, 4'd0);
    apply("post.flag4", 16'h1EC8, 0, 0, 4'd0, 4'b0000, 1, 0, 0, 4'd0);

`ifdef INTCTL_EDGE_EN
    apply("e.mask0", 16'h1EE0, 1, 1, 4'd0, 4'b0000, 1, 0, 0, 4'd0);
    for (int c = 1; c <= 10; c++) begin
      logic ei;
      ei = (c >= 2 && c <= 5);
      if (c == 5)
        apply($sformatf("e.hold%0d", c), 16'h1EC4, 0, 0, 4'd5, 4'b0001, 1, 0, ei, ei ? 4'd1 : 4'd0);
      else
        apply($sformatf("e.hold%0d", c), 16'h0000, 0, 0, 4'd0, 4'b0001, 0, 1, ei, ei ? 4'd1 : 4'd0);
    end
    apply("e.fall",  16'h0000, 0, 0, 4'd0, 4'b0000, 0, 1, 0, 4'd0);
    apply("e.rise",  16'h0000, 0, 0, 4'd0, 4'b0001, 0, 1, 0, 4'd0);
    apply("e.seen",  16'h0000, 0, 0, 4'd0, 4'b0001, 0, 1, 1, 4'd1);
    apply("e.ack",   16'h1EC4, 0, 0, 4'd5, 4'b0000, 1, 0, 1, 4'd1);
    apply("e.idle",  16'h0000, 0, 0, 4'd0, 4'b0000, 0, 1, 0, 4'd0);
    apply("e.both",  16'h1EC4, 0, 0, 4'd5, 4'b0001, 1, 0, 0, 4'd0);
    apply("e.kept",  16'h0000, 0, 0, 4'd0, 4'b0001, 0, 1, 1, 4'd1);
    apply("e.kept2", 16'h0000, 0, 0, 4'd0, 4'b0000, 0, 1, 1, 4'd1);
`else
    apply("l.mask0", 16'h1EE0, 1, 1, 4'd0, 4'b0000, 1, 0, 0, 4'd0);
    apply("l.live",  16'h0000, 0, 0, 4'd0, 4'b0001, 0, 1, 1, 4'd1);
    apply("l.both",  16'h1EC4, 0, 0, 4'd5, 4'b0001, 1, 0, 1, 4'd1);
    apply("l.kept",  16'h0000, 0, 0, 4'd0, 4'b0000, 0, 1, 1, 4'd1);
    apply("l.ack",   16'h1EC4, 0, 0, 4'd5, 4'b0000, 1, 0, 1, 4'd1);
    apply("l.idle",  16'h0000, 0, 0, 4'd0, 4'b0000, 0, 1, 0, 4'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
